// File: rtl/uart_tx_word_fifo.sv
// Word-wide transmit queue in front of a byte-serial UART sender.
// Words of 1..BYTES bytes are queued in a circular FIFO, then a small FSM
// (IDLE -> SEND -> GAP) strobes them out one byte at a time. It honours
// sender_ready and always leaves at least one idle cycle between strobes.
//
// Handshakes (both are single-cycle strobes, no back-pressure on push):
//   push side   : a word is taken at the edge when push=1, flush=0 and
//                 full=0. A push while full is dropped and sets the sticky
//                 overflow flag. A push during flush is dropped silently.
//   sender side : sender_enable is the valid; sender_ready is the ready.
//                 sender_enable is only raised in SEND and equals
//                 sender_ready there, so a byte transfers on the edge where
//                 both are high. sender_data is registered and holds the
//                 byte for every cycle the FSM sits in SEND.
module uart_tx_word_fifo #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int BYTE_ORDER = 0
) (
    input  logic                          CLK,
    input  logic                          reset_n,
    input  logic [WORD_WIDTH-1:0]         push_data,
    input  logic [$clog2(WORD_WIDTH/8):0] push_len,
    input  logic                          push,
    input  logic                          flush,
    input  logic                          sender_ready,
    output logic [7:0]                    sender_data,
    output logic                          sender_enable,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          busy,
    output logic                          overflow,
    output logic [1:0]                    dbg_state
);

    localparam int BYTES = WORD_WIDTH / 8;
    localparam int LW    = $clog2(BYTES) + 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Byte presented first from an aligned shift register.
    function automatic logic [7:0] lead_byte(input logic [WORD_WIDTH-1:0] w);
        if (BYTE_ORDER == 0) begin
            return w[WORD_WIDTH-1 -: 8];
        end
        return w[7:0];
    endfunction

    // Shift register after one byte has been consumed.
    function automatic logic [WORD_WIDTH-1:0] advance(input logic [WORD_WIDTH-1:0] w);
        if (BYTE_ORDER == 0) begin
            return w << 8;
        end
        return w >> 8;
    endfunction

    // Storage and pointers
    logic [WORD_WIDTH-1:0] r_mem_word [DEPTH];
    logic [LW-1:0]         r_mem_len  [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;

    // Transmit side
    state_t                r_state;
    state_t                w_state_next;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [LW-1:0]         r_bytes_left;
    logic [7:0]            r_sender_data;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_ok;
    logic                  w_push_drop;
    logic                  w_pop;
    logic                  w_enable;
    logic                  w_send_fire;
    logic [LW-1:0]         w_push_len_eff;
    logic [WORD_WIDTH-1:0] w_head_word;
    logic [LW-1:0]         w_head_len;
    logic [WORD_WIDTH-1:0] w_head_aligned;
    logic [WORD_WIDTH-1:0] w_shift_adv;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push_ok   = push && !flush && !w_full;
    assign w_push_drop = push && !flush && w_full;
    assign w_send_fire = (r_state == S_SEND) && sender_ready;
    assign w_head_word = r_mem_word[r_rd_ptr];
    assign w_head_len  = r_mem_len[r_rd_ptr];
    assign w_shift_adv = advance(r_shift);

    // Normalise the requested length: 0 or anything above BYTES means a full word.
    always_comb begin
        w_push_len_eff = push_len;
        if (push_len == '0 || push_len > LW'(BYTES)) begin
            w_push_len_eff = LW'(BYTES);
        end
    end

    // Align the head word so its first byte to send sits in the lead byte lane.
    always_comb begin
        w_head_aligned = w_head_word;
        if (BYTE_ORDER == 0) begin
            w_head_aligned = w_head_word << (8 * (BYTES - int'(w_head_len)));
        end
    end

    // FSM next state, pop request and transmit strobe.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_enable     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                w_enable = sender_ready;
                if (sender_ready) begin
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                w_state_next = (r_bytes_left != '0) ? S_SEND : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // A flush abandons the current word and must not consume the queue.
        if (flush) begin
            w_state_next = S_IDLE;
            w_pop        = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Queue storage; entries hold the normalised length next to the word.
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem_word[r_wr_ptr] <= push_data;
            r_mem_len[r_wr_ptr]  <= w_push_len_eff;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (!reset_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: set by a push that found the queue full.
    always_ff @(posedge CLK) begin
        if (!reset_n || flush) begin
            r_overflow <= 1'b0;
        end else if (w_push_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Shift register, remaining-byte counter and registered output byte.
    always_ff @(posedge CLK) begin
        if (!reset_n || flush) begin
            r_shift       <= '0;
            r_bytes_left  <= '0;
            r_sender_data <= 8'h00;
        end else if (w_pop) begin
            r_shift       <= w_head_aligned;
            r_bytes_left  <= w_head_len;
            r_sender_data <= lead_byte(w_head_aligned);
        end else if (w_send_fire) begin
            r_shift       <= w_shift_adv;
            r_bytes_left  <= r_bytes_left - LW'(1);
            r_sender_data <= lead_byte(w_shift_adv);
        end
    end

    assign sender_data   = r_sender_data;
    assign sender_enable = w_enable;
    assign full          = w_full;
    assign empty         = w_empty;
    assign count         = r_count;
    assign busy          = (r_state != S_IDLE);
    assign overflow      = r_overflow;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_uart_tx_word_fifo.sv
// Bench for uart_tx_word_fifo: two instances (MSB-first and LSB-first) share
// one stimulus stream; a byte-level reference queue per instance predicts
// the transmitted stream from the pushed words and lengths.
module tb_uart_tx_word_fifo;

    localparam int WW    = 32;
    localparam int DEPTH = 16;
    localparam int BYTES = 4;
    localparam int LW    = 3;
    localparam int CW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [WW-1:0] push_data;
    logic [LW-1:0] push_len;
    logic          push;
    logic          flush;
    logic          sender_ready;

    logic [7:0]    sd0, sd1;
    logic          en0, en1;
    logic          full0, full1;
    logic          empty0, empty1;
    logic [CW-1:0] count0, count1;
    logic          busy0, busy1;
    logic          ovf0, ovf1;
    logic [1:0]    st0, st1;

    uart_tx_word_fifo #(.WORD_WIDTH(WW), .DEPTH(DEPTH), .BYTE_ORDER(0)) dut0 (
        .CLK(clk), .reset_n(reset_n), .push_data(push_data), .push_len(push_len),
        .push(push), .flush(flush), .sender_ready(sender_ready),
        .sender_data(sd0), .sender_enable(en0), .full(full0), .empty(empty0),
        .count(count0), .busy(busy0), .overflow(ovf0), .dbg_state(st0)
    );

    uart_tx_word_fifo #(.WORD_WIDTH(WW), .DEPTH(DEPTH), .BYTE_ORDER(1)) dut1 (
        .CLK(clk), .reset_n(reset_n), .push_data(push_data), .push_len(push_len),
        .push(push), .flush(flush), .sender_ready(sender_ready),
        .sender_data(sd1), .sender_enable(en1), .full(full1), .empty(empty1),
        .count(count1), .busy(busy1), .overflow(ovf1), .dbg_state(st1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: expected byte streams and outstanding word lengths.
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         exp_len_q[$];
    logic [7:0] got0[$];
    logic [7:0] got1[$];
    int         n_strobes = 0;
    int         cur_bytes = 0;
    logic       prev_en   = 1'b0;
    bit         mon_en    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_exp(input logic [WW-1:0] data, input logic [LW-1:0] len);
        int n;
        n = (len == 0 || int'(len) > BYTES) ? BYTES : int'(len);
        for (int k = n - 1; k >= 0; k--) exp_q0.push_back(data[8*k +: 8]);
        for (int k = 0; k < n; k++) exp_q1.push_back(data[8*k +: 8]);
        exp_len_q.push_back(n);
    endtask

    task automatic clear_model();
        exp_q0.delete();
        exp_q1.delete();
        exp_len_q.delete();
        cur_bytes = 0;
    endtask

    // Byte monitor: protocol rules plus scoreboard comparison on every strobe.
    always @(negedge clk) begin
        if (mon_en) begin
            check("en_match", en1, en0);
            if (en0) begin
                check("strobe_while_not_ready", sender_ready, 1);
                check("consecutive_strobe", prev_en, 0);
                n_strobes++;
                got0.push_back(sd0);
                got1.push_back(sd1);
                check("strobe_expected", exp_q0.size() != 0, 1);
                if (exp_q0.size() != 0) begin
                    check("byte_msb_first", sd0, exp_q0.pop_front());
                    check("byte_lsb_first", sd1, exp_q1.pop_front());
                    cur_bytes++;
                    if (exp_len_q.size() != 0 && cur_bytes == exp_len_q[0]) begin
                        void'(exp_len_q.pop_front());
                        cur_bytes = 0;
                    end
                end
            end
            prev_en = en0;
        end
    end

    // Drive one push for a cycle; the caller states whether it should be taken.
    task automatic push_word(input logic [WW-1:0] data, input logic [LW-1:0] len, input bit accept);
        push_data = data;
        push_len  = len;
        push      = 1'b1;
        if (accept) add_exp(data, len);
        @(posedge clk); #1;
        push = 1'b0;
    endtask

    // Returns in the cycle after the n-th new strobe.
    task automatic wait_strobes(input int n, input int budget);
        int start;
        int cyc;
        start = n_strobes;
        cyc   = 0;
        while (n_strobes < start + n && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("wait_strobes_timeout", (n_strobes - start) >= n, 1);
    endtask

    task automatic wait_drain(input int budget);
        int cyc;
        cyc = 0;
        while ((exp_q0.size() != 0 || busy0 || !empty0) && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_timeout", {exp_q0.size() == 0, busy0, empty0}, 3'b101);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data0"}, sd0, 8'h00);
        check({tag, "_data1"}, sd1, 8'h00);
        check({tag, "_enable"}, {en0, en1}, 2'b00);
        check({tag, "_empty"}, {empty0, empty1}, 2'b11);
        check({tag, "_full"}, {full0, full1}, 2'b00);
        check({tag, "_busy"}, {busy0, busy1}, 2'b00);
        check({tag, "_overflow"}, {ovf0, ovf1}, 2'b00);
        check({tag, "_count"}, count0, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_a0 [4];
        logic [7:0] exp_a1 [4];
        int         s0;
        int         pushes;
        int         cyc;
        int         total_bytes;
        logic [LW-1:0] rlen;
        logic [WW-1:0] rdata;

        exp_a0 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        exp_a1 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

        reset_n      = 1'b0;
        push         = 1'b0;
        flush        = 1'b0;
        sender_ready = 1'b1;
        push_data    = '0;
        push_len     = '0;

        // Clock/reset
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_reset_values("reset");
        mon_en = 1'b1;

        // DEADBEEF, full length, ready held high: strobes at t+2, t+4, t+6, t+8.
        got0.delete(); got1.delete();
        push_word(32'hDEADBEEF, 3'd0, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("latency_en_c%0d", c), en0, (c == 2 || c == 4 || c == 6 || c == 8) ? 1 : 0);
            if (c == 1) begin
                check("count_after_push", count0, 1);
                check("busy_before_pop", busy0, 0);
            end
        end
        check("busy_after_word", busy0, 0);
        check("word_a_nbytes", got0.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("word_a_msb_b%0d", i), got0[i], exp_a0[i]);
            check($sformatf("word_a_lsb_b%0d", i), got1[i], exp_a1[i]);
        end
        @(posedge clk); #1;

        // Short word: two low-order bytes only.
        got0.delete(); got1.delete();
        push_word(32'h11223344, 3'd2, 1'b1);
        wait_drain(50);
        check("short_nbytes", got1.size(), 2);
        check("short_lsb_b0", got1[0], 8'h44);
        check("short_lsb_b1", got1[1], 8'h33);
        check("short_msb_b0", got0[0], 8'h33);
        check("short_msb_b1", got0[1], 8'h44);

        // Fill while the sender is stalled: word 1 sits in the shifter,
        // words 2..17 fill the queue, word 18 is dropped.
        sender_ready = 1'b0;
        got0.delete(); got1.delete();
        s0 = n_strobes;
        for (int i = 1; i <= 18; i++) push_word($urandom, 3'd0, i <= 17);
        check("fill_count", count0, 16);
        check("fill_full", full0, 1);
        check("fill_overflow", ovf0, 1);
        check("fill_empty", empty0, 0);
        check("fill_busy", busy0, 1);
        sender_ready = 1'b1;
        wait_drain(17 * 4 * 2 + 50);
        check("fill_strobes", n_strobes - s0, 68);
        check("overflow_sticky", ovf0, 1);

        // Flush after the second byte of a word with three words queued.
        sender_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word($urandom, 3'd0, 1'b1);
        check("flush_pre_count", count0, 3);
        sender_ready = 1'b1;
        wait_strobes(2, 20);
        flush = 1'b1;
        clear_model();
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_count", count0, 0);
        check("flush_busy", busy0, 0);
        check("flush_overflow", ovf0, 0);
        check("flush_empty", empty0, 1);
        s0 = n_strobes;
        repeat (20) begin @(posedge clk); #1; end
        check("flush_no_strobes", n_strobes - s0, 0);

        // Push coinciding with flush while full: flush wins, no overflow.
        sender_ready = 1'b0;
        for (int i = 0; i < 17; i++) push_word($urandom, 3'd0, 1'b0);
        check("pf_full", full0, 1);
        push_data = $urandom;
        push      = 1'b1;
        flush     = 1'b1;
        @(posedge clk); #1;
        push  = 1'b0;
        flush = 1'b0;
        check("pf_overflow", ovf0, 0);
        check("pf_count", count0, 0);
        check("pf_busy", busy0, 0);

        // Reset in the middle of a word with five words queued.
        for (int i = 0; i < 6; i++) push_word($urandom, 3'd0, 1'b1);
        check("rst_pre_count", count0, 5);
        sender_ready = 1'b1;
        wait_strobes(1, 20);
        reset_n = 1'b0;
        clear_model();
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_reset_values("rst_mid");
        s0 = n_strobes;
        repeat (10) begin @(posedge clk); #1; end
        check("rst_no_strobes", n_strobes - s0, 0);
        got0.delete(); got1.delete();
        push_word(32'hCAFEF00D, 3'd3, 1'b1);
        wait_drain(50);
        check("post_rst_nbytes", got0.size(), 3);
        check("post_rst_msb_b0", got0[0], 8'hFE);
        check("post_rst_msb_b2", got0[2], 8'h0D);
        check("post_rst_lsb_b0", got1[0], 8'h0D);

        // Random ready and random pushes; pushes are only offered while the
        // model's outstanding word count guarantees room in the queue.
        s0          = n_strobes;
        pushes      = 0;
        cyc         = 0;
        total_bytes = 0;
        while (pushes < 1000 && cyc < 60000) begin
            sender_ready = 1'($urandom_range(0, 1));
            if (exp_len_q.size() < DEPTH && $urandom_range(0, 2) == 0) begin
                rdata     = $urandom;
                rlen      = LW'($urandom_range(0, 7));
                push_data = rdata;
                push_len  = rlen;
                push      = 1'b1;
                add_exp(rdata, rlen);
                total_bytes += (rlen == 0 || int'(rlen) > BYTES) ? BYTES : int'(rlen);
                pushes++;
            end else begin
                push = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        push = 1'b0;
        check("rand_pushes", pushes, 1000);
        sender_ready = 1'b1;
        wait_drain(DEPTH * BYTES * 2 + 50);
        check("rand_strobes", n_strobes - s0, total_bytes);
        check("rand_overflow", ovf0, 0);
        check("rand_count", count0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
